// File: rtl/energy_frame_tx_if.sv
// Sample input and UART status bundle for the energy telemetry framer.
// The slave modport is the framer side; the master modport is the sample producer and status consumer.
interface energy_frame_tx_if;
  logic       ena;
  logic       sample_valid;
  logic [7:0] volt;
  logic [7:0] curr;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  modport master (
    output ena, sample_valid, volt, curr,
    input  tx, busy, frame_done, overrun
  );

  modport slave (
    input  ena, sample_valid, volt, curr,
    output tx, busy, frame_done, overrun
  );
endinterface

// File: rtl/energy_frame_tx.sv
// Windowed power/energy accumulator with a 7-byte 8N1 UART frame transmitter.
// state   | meaning
// S_IDLE  | line high, waiting for a window to close
// S_START | start bit of the current byte
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit; then the next byte, or frame end
module energy_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WINDOW       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  energy_frame_tx_if.slave   bus
);
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [19:0]   r_acc;
  logic [15:0]   r_peak;
  logic [CW-1:0] r_cnt;
  logic [19:0]   r_energy;
  logic [15:0]   r_pk;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [2:0]    r_byte;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic          r_overrun;

  logic          w_accept;
  logic [15:0]   w_p;
  logic [19:0]   w_acc_nxt;
  logic [15:0]   w_peak_nxt;
  logic          w_close;
  logic          w_baud_tc;
  logic          w_frame_end;
  logic          w_launch;
  logic [2:0]    w_nidx;
  logic [7:0]    w_chk;
  logic [7:0]    w_next_byte;

  assign w_accept    = bus.ena & bus.sample_valid;
  assign w_p         = bus.volt * bus.curr;
  assign w_acc_nxt   = r_acc + {4'h0, w_p};
  assign w_peak_nxt  = (w_p > r_peak) ? w_p : r_peak;
  assign w_close     = w_accept && (r_cnt == CW'(WINDOW - 1));
  assign w_baud_tc   = (r_baud == '0);
  assign w_frame_end = (r_state == S_STOP) && w_baud_tc && (r_byte == 3'd6);
  // A window closing on the very edge the last stop bit ends starts a new frame.
  assign w_launch    = w_close && ((r_state == S_IDLE) || w_frame_end);
  assign w_nidx      = r_byte + 3'd1;
  assign w_chk       = {4'h0, r_energy[19:16]} ^ r_energy[15:8] ^ r_energy[7:0]
                     ^ r_pk[15:8] ^ r_pk[7:0];

  always_comb begin
    w_next_byte = 8'hA5;
    case (w_nidx)
      3'd1:    w_next_byte = {4'h0, r_energy[19:16]};
      3'd2:    w_next_byte = r_energy[15:8];
      3'd3:    w_next_byte = r_energy[7:0];
      3'd4:    w_next_byte = r_pk[15:8];
      3'd5:    w_next_byte = r_pk[7:0];
      3'd6:    w_next_byte = w_chk;
      default: w_next_byte = 8'hA5;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_peak    <= '0;
      r_cnt     <= '0;
      r_energy  <= '0;
      r_pk      <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_acc  <= '0;
          r_peak <= '0;
          r_cnt  <= '0;
        end else begin
          r_acc  <= w_acc_nxt;
          r_peak <= w_peak_nxt;
          r_cnt  <= r_cnt + 1'b1;
        end
      end
      if (w_launch) begin
        r_energy <= w_acc_nxt;
        r_pk     <= w_peak_nxt;
      end
      if (w_close && !w_launch) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_state <= S_START;
        r_tx    <= 1'b0;
        r_busy  <= 1'b1;
        r_byte  <= '0;
        r_shift <= 8'hA5;
        r_baud  <= BW'(CLKS_PER_BIT - 1);
        if (w_frame_end) r_done <= 1'b1;
      end else begin
        case (r_state)
          S_START: begin
            if (w_baud_tc) begin
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= '0;
              r_baud  <= BW'(CLKS_PER_BIT - 1);
            end else r_baud <= r_baud - 1'b1;
          end
          S_DATA: begin
            if (w_baud_tc) begin
              r_baud <= BW'(CLKS_PER_BIT - 1);
              if (r_bit == 3'd7) begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end else begin
                r_tx    <= r_shift[0];
                r_shift <= r_shift >> 1;
                r_bit   <= r_bit + 3'd1;
              end
            end else r_baud <= r_baud - 1'b1;
          end
          S_STOP: begin
            if (w_baud_tc) begin
              if (r_byte == 3'd6) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_START;
                r_byte  <= w_nidx;
                r_shift <= w_next_byte;
                r_tx    <= 1'b0;
                r_baud  <= BW'(CLKS_PER_BIT - 1);
              end
            end else r_baud <= r_baud - 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tx         = r_tx;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_energy_frame_tx.sv
// Bench for energy_frame_tx: table-driven windows, UART decoder feeding a byte scoreboard,
// plus hand-written ena gating, back-to-back, overrun and mid-frame reset sequences.
module tb_energy_frame_tx;
  localparam int CPB = 4;
  localparam int WIN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  energy_frame_tx_if bus();

  energy_frame_tx #(.CLKS_PER_BIT(CPB), .WINDOW(WIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] v;    // sample 0 in the top byte
    logic [31:0] c;
    logic [55:0] exp;  // B0 in the top byte
  } vec_t;

  int         n_chk = 0;
  int         n_fail = 0;
  int         n_done = 0;
  int         exp_done = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b1;
  logic [7:0] mon_b;
  vec_t       tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] model(input logic [31:0] v, input logic [31:0] c);
    logic [19:0] e;
    logic [15:0] pk;
    logic [15:0] p;
    logic [7:0]  vv, cc, b1, b2, b3, b4, b5;
    e = '0;
    pk = '0;
    for (int i = 0; i < 4; i++) begin
      vv = v[31-8*i -: 8];
      cc = c[31-8*i -: 8];
      p = vv * cc;
      e = e + {4'h0, p};
      if (p > pk) pk = p;
    end
    b1 = {4'h0, e[19:16]};
    b2 = e[15:8];
    b3 = e[7:0];
    b4 = pk[15:8];
    b5 = pk[7:0];
    return {8'hA5, b1, b2, b3, b4, b5, b1 ^ b2 ^ b3 ^ b4 ^ b5};
  endfunction

  task automatic push_exp(input logic [55:0] f);
    for (int i = 0; i < 7; i++) exp_q.push_back(f[55-8*i -: 8]);
    exp_done++;
  endtask

  task automatic drive(input logic [7:0] v, input logic [7:0] c, input logic en);
    bus.volt = v;
    bus.curr = c;
    bus.ena = en;
    bus.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic run_window(input logic [31:0] v, input logic [31:0] c);
    for (int i = 0; i < 4; i++) drive(v[31-8*i -: 8], c[31-8*i -: 8], 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((bus.busy || exp_q.size() != 0) && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, (k < 2000) ? 32'd1 : 32'd0, 32'd1);
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  // UART decoder: a low line on a falling edge is the first cycle of a start bit.
  initial forever begin
    @(negedge clk);
    if (rst_n && mon_en && bus.tx === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = bus.tx;
      end
      repeat (CPB) @(negedge clk);
      check("stop_bit", {31'd0, bus.tx}, 32'd1);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_byte: got %0h expected no byte", mon_b);
      end else check("frame_byte", {24'd0, mon_b}, {24'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) if (rst_n && bus.frame_done) n_done++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] f;
    logic [31:0] rv, rc;
    int          k;

    tbl[0] = '{v: 32'h0A0A0A0A, c: 32'h14141414, exp: 56'hA5_00_03_20_00_C8_EB};
    tbl[1] = '{v: 32'hFFFFFFFF, c: 32'hFFFFFFFF, exp: 56'hA5_03_F8_04_FE_01_00};
    tbl[2] = '{v: 32'h0A0A0A0A, c: 32'h0A1E051E, exp: 56'hA5_00_02_EE_01_2C_C1};
    tbl[3] = '{v: 32'h00000000, c: 32'hFF7F0102, exp: 56'hA5_00_00_00_00_00_00};

    bus.ena = 1'b0;
    bus.sample_valid = 1'b0;
    bus.volt = '0;
    bus.curr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, bus.tx}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      push_exp(tbl[i].exp);
      run_window(tbl[i].v, tbl[i].c);
      check("launch_busy", {31'd0, bus.busy}, 32'd1);
      if (i == 0) begin
        k = 0;
        while (bus.busy && k < 1000) begin
          @(posedge clk);
          #1;
          k++;
        end
        check("busy_len", k, 70 * CPB);
      end
      wait_idle("drain_table");
      check("frame_done_cnt", n_done, exp_done);
    end

    for (int i = 0; i < 3; i++) begin
      rv = $urandom();
      rc = $urandom();
      push_exp(model(rv, rc));
      run_window(rv, rc);
      wait_idle("drain_random");
    end
    check("frame_done_cnt_rand", n_done, exp_done);

    // ena gating: disabled valids are ignored and do not advance the window.
    drive(8'd3, 8'd11, 1'b1);
    drive(8'hFF, 8'hFF, 1'b0);
    drive(8'd5, 8'd13, 1'b1);
    drive(8'hFF, 8'hFF, 1'b0);
    drive(8'd7, 8'd17, 1'b1);
    drive(8'hFF, 8'hFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("ena_no_frame_busy", {31'd0, bus.busy}, 32'd0);
    check("ena_no_frame_tx", {31'd0, bus.tx}, 32'd1);
    push_exp(model(32'h03050709, 32'h0B0D1113));
    drive(8'd9, 8'd19, 1'b1);
    check("ena_launch_busy", {31'd0, bus.busy}, 32'd1);
    drive(8'hFF, 8'hFF, 1'b0);
    wait_idle("drain_ena");

    // Window closing exactly on the edge the previous frame ends launches a new frame.
    f = model(32'h01020304, 32'h05060708);
    push_exp(f);
    run_window(32'h01020304, 32'h05060708);
    drive(8'd20, 8'd30, 1'b1);
    drive(8'd40, 8'd50, 1'b1);
    drive(8'd60, 8'd70, 1'b1);
    repeat (70 * CPB - 4) @(posedge clk);
    #1;
    check("b2b_busy_before", {31'd0, bus.busy}, 32'd1);
    push_exp(model(32'h14283C50, 32'h1E324655));
    drive(8'd80, 8'd85, 1'b1);
    check("b2b_done_pulse", {31'd0, bus.frame_done}, 32'd1);
    check("b2b_busy_after", {31'd0, bus.busy}, 32'd1);
    check("b2b_overrun", {31'd0, bus.overrun}, 32'd0);
    wait_idle("drain_b2b");
    check("frame_done_cnt_b2b", n_done, exp_done);

    // Overrun: a second window closing mid-frame is dropped.
    push_exp(tbl[0].exp);
    run_window(tbl[0].v, tbl[0].c);
    run_window(32'hFFFFFFFF, 32'hFFFFFFFF);
    check("ovr_set", {31'd0, bus.overrun}, 32'd1);
    wait_idle("drain_ovr");
    repeat (20) @(posedge clk);
    #1;
    check("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
    check("ovr_no_second", {31'd0, bus.busy}, 32'd0);
    check("frame_done_cnt_ovr", n_done, exp_done);

    // Mid-frame reset during B2, with a partial window accumulated.
    mon_en = 1'b0;
    run_window(tbl[1].v, tbl[1].c);
    drive(8'hFF, 8'hFF, 1'b1);
    drive(8'hFF, 8'hFF, 1'b1);
    repeat (22 * CPB - 2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", {31'd0, bus.tx}, 32'd1);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_overrun", {31'd0, bus.overrun}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_no_done", n_done, exp_done);
    push_exp(tbl[2].exp);
    run_window(tbl[2].v, tbl[2].c);
    wait_idle("drain_post_rst");
    check("frame_done_cnt_final", n_done, exp_done);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
